// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops with a registered result and latency 1.
// MULT is an iterative signed shift-add over DATA_W cycles into HI/LO, with stall while it runs.
module alu_exec_unit #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               valid_in,
  output logic               ready_out,
  input  logic [3:0]         alu_control,
  input  logic [DATA_W-1:0]  operand_a,
  input  logic [DATA_W-1:0]  operand_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               valid_out,
  output logic [DATA_W-1:0]  result,
  output logic               zero,
  output logic [DATA_W-1:0]  hi,
  output logic [DATA_W-1:0]  lo,
  output logic               stall
);

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_W-1:0]     r_mcand;
  logic [DATA_W-1:0]     r_mplier;
  logic [2*DATA_W-1:0]   r_acc;
  logic [SHAMT_W-1:0]    r_cnt;
  logic                  r_sign;
  logic [DATA_W-1:0]     r_result;
  logic                  r_zero;
  logic                  r_valid;
  logic [DATA_W-1:0]     r_hi;
  logic [DATA_W-1:0]     r_lo;

  logic                  w_accept;
  logic                  w_is_mult;
  logic                  w_last;
  logic [DATA_W-1:0]     w_alu;
  logic [DATA_W-1:0]     w_abs_a;
  logic [DATA_W-1:0]     w_abs_b;
  logic [DATA_W-1:0]     w_addend;
  logic [DATA_W:0]       w_upper_sum;
  logic [2*DATA_W-1:0]   w_acc_step;
  logic [2*DATA_W-1:0]   w_prod;

  assign w_accept  = valid_in && (r_state == S_IDLE);
  assign w_is_mult = (alu_control == 4'd9);
  assign w_last    = (r_cnt == SHAMT_W'(DATA_W - 1));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_mult) w_state_nxt = S_MUL;
      S_MUL:   if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready_out = (r_state == S_IDLE);
    stall     = (r_state == S_MUL);
  end

  always_comb begin
    w_alu = '0;
    case (alu_control)
      4'd0:    w_alu = operand_a & operand_b;
      4'd1:    w_alu = operand_a | operand_b;
      4'd2:    w_alu = operand_a + operand_b;
      4'd3:    w_alu = operand_b << shamt;
      4'd4:    w_alu = operand_b >> shamt;
      4'd5:    w_alu = operand_a - operand_b;
      4'd7:    w_alu = {{(DATA_W-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      4'd12:   w_alu = ~(operand_a | operand_b);
      default: w_alu = '0;
    endcase
  end

  // Magnitudes are unsigned, so |-2^(DATA_W-1)| still fits in DATA_W bits.
  assign w_abs_a     = operand_a[DATA_W-1] ? (~operand_a + 1'b1) : operand_a;
  assign w_abs_b     = operand_b[DATA_W-1] ? (~operand_b + 1'b1) : operand_b;
  assign w_addend    = r_mplier[0] ? r_mcand : '0;
  assign w_upper_sum = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + {1'b0, w_addend};
  assign w_acc_step  = {w_upper_sum, r_acc[DATA_W-1:1]};
  assign w_prod      = r_sign ? (~w_acc_step + 1'b1) : w_acc_step;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_valid  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_valid <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_accept && w_is_mult) begin
          r_mcand  <= w_abs_a;
          r_mplier <= w_abs_b;
          r_sign   <= operand_a[DATA_W-1] ^ operand_b[DATA_W-1];
          r_acc    <= '0;
          r_cnt    <= '0;
        end else if (w_accept) begin
          r_result <= w_alu;
          r_zero   <= (w_alu == '0);
          r_valid  <= 1'b1;
        end
      end else begin
        r_acc    <= w_acc_step;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        if (w_last) begin
          r_hi     <= w_prod[2*DATA_W-1:DATA_W];
          r_lo     <= w_prod[DATA_W-1:0];
          r_result <= w_prod[DATA_W-1:0];
          r_zero   <= (w_prod[DATA_W-1:0] == '0);
          r_valid  <= 1'b1;
        end
      end
    end
  end

  assign valid_out = r_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign hi        = r_hi;
  assign lo        = r_lo;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed cases plus random ops against an arithmetic reference model.
module tb_alu_exec_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          valid_in;
  logic          ready_out;
  logic [3:0]    alu_control;
  logic [W-1:0]  operand_a;
  logic [W-1:0]  operand_b;
  logic [4:0]    shamt;
  logic          valid_out;
  logic [W-1:0]  result;
  logic          zero;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          stall;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  alu_exec_unit #(.DATA_W(W), .SHAMT_W(5)) dut (
    .clk(clk), .arst_n(arst_n), .valid_in(valid_in), .ready_out(ready_out),
    .alu_control(alu_control), .operand_a(operand_a), .operand_b(operand_b),
    .shamt(shamt), .valid_out(valid_out), .result(result), .zero(zero),
    .hi(hi), .lo(lo), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [4:0] sh);
    int ia, ib;
    ia = a;
    ib = b;
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return W'(a + b);
      4'd3:    return W'(b * (64'd1 << sh));
      4'd4:    return W'(b / (64'd1 << sh));
      4'd5:    return W'(a - b);
      4'd7:    return (ia < ib) ? 32'd1 : 32'd0;
      4'd12:   return ~(a | b);
      default: return '0;
    endcase
  endfunction

  function automatic logic [63:0] ref_mult(input logic [W-1:0] a, input logic [W-1:0] b);
    int ia, ib;
    longint p;
    ia = a;
    ib = b;
    p = longint'(ia) * longint'(ib);
    return p;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, ".ready"},  ready_out, 1);
    chk({tag, ".stall"},  stall, 0);
    chk({tag, ".valid"},  valid_out, 0);
    chk({tag, ".result"}, result, 0);
    chk({tag, ".zero"},   zero, 1);
    chk({tag, ".hi"},     hi, 0);
    chk({tag, ".lo"},     lo, 0);
  endtask

  // Issue one single-cycle op; leaves valid_in low afterwards unless the caller re-issues.
  task automatic issue(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [4:0] sh);
    logic [W-1:0] e;
    e = ref_alu(op, a, b, sh);
    alu_control = op; operand_a = a; operand_b = b; shamt = sh; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    chk({tag, ".valid"},  valid_out, 1);
    chk({tag, ".result"}, result, e);
    chk({tag, ".zero"},   zero, (e == 0));
    chk({tag, ".hi"},     hi, exp_hi);
    chk({tag, ".lo"},     lo, exp_lo);
  endtask

  task automatic run_mult(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit hold_add);
    logic [63:0] p;
    int n, low, bad_stall;
    logic [W-1:0] add_a, add_b;
    p = ref_mult(a, b);
    alu_control = 4'd9; operand_a = a; operand_b = b; shamt = 5'($urandom); valid_in = 1'b1;
    @(posedge clk); #1;
    add_a = $urandom; add_b = $urandom;
    if (hold_add) begin
      alu_control = 4'd2; operand_a = add_a; operand_b = add_b;
    end else begin
      valid_in = 1'b0;
    end
    n = 0; low = 0; bad_stall = 0;
    while (!valid_out && n < 100) begin
      if (!ready_out) low++;
      if (stall !== ~ready_out) bad_stall++;
      if (!hold_add) begin
        alu_control = 4'($urandom); operand_a = $urandom; operand_b = $urandom;
      end
      @(posedge clk); #1;
      n++;
    end
    exp_hi = p[63:32];
    exp_lo = p[31:0];
    chk({tag, ".cycles"},  n, W);
    chk({tag, ".lowcyc"},  low, W);
    chk({tag, ".stallok"}, bad_stall, 0);
    chk({tag, ".valid"},   valid_out, 1);
    chk({tag, ".ready"},   ready_out, 1);
    chk({tag, ".hi"},      hi, exp_hi);
    chk({tag, ".lo"},      lo, exp_lo);
    chk({tag, ".result"},  result, exp_lo);
    chk({tag, ".zero"},    zero, (exp_lo == 0));
    if (hold_add) begin
      @(posedge clk); #1;
      valid_in = 1'b0;
      chk({tag, ".add_valid"},  valid_out, 1);
      chk({tag, ".add_result"}, result, W'(add_a + add_b));
      chk({tag, ".add_hi"},     hi, exp_hi);
      @(posedge clk); #1;
      chk({tag, ".one_pulse"},  valid_out, 0);
    end else begin
      valid_in = 1'b0;
    end
  endtask

  initial begin
    valid_in = 1'b0; alu_control = '0; operand_a = '0; operand_b = '0; shamt = '0;
    arst_n = 1'b0;
    #12;
    chk_reset_state("reset");
    @(posedge clk); #1;
    arst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_state("post_reset");

    issue("add_ovf", 4'd2, 32'h7FFF_FFFF, 32'd1, 5'd0);
    issue("sub_zero", 4'd5, 32'd5, 32'd5, 5'd0);
    issue("slt_neg", 4'd7, 32'hFFFF_FFFF, 32'd1, 5'd0);
    issue("slt_pos", 4'd7, 32'd1, 32'hFFFF_FFFF, 5'd0);
    issue("sll31", 4'd3, 32'h0, 32'd1, 5'd31);
    issue("srl31", 4'd4, 32'h0, 32'h8000_0000, 5'd31);
    issue("nor", 4'd12, 32'h0F0F_0000, 32'h0000_00FF, 5'd0);
    issue("undef6", 4'd6, 32'h1234, 32'h5678, 5'd3);
    @(posedge clk); #1;
    chk("idle_no_pulse", valid_out, 0);

    run_mult("mul_m3x7", 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_mult("mul_min", 32'h8000_0000, 32'h8000_0000, 1'b0);
    issue("add_after_mul", 4'd2, 32'd100, 32'd23, 5'd0);
    run_mult("mul_zero", 32'hDEAD_BEEF, 32'd0, 1'b0);
    run_mult("mul_hold", 32'd12345, 32'hFFFF_FC19, 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (op == 4'd9) op = 4'd2;
      issue("rand_op", op, $urandom, $urandom, 5'($urandom));
    end
    for (int i = 0; i < 4; i++) begin
      run_mult("rand_mul", $urandom, $urandom, 1'b0);
    end

    alu_control = 4'd9; operand_a = 32'd12345; operand_b = 32'hFFFF_FC19; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    arst_n = 1'b0;
    #1;
    exp_hi = '0;
    exp_lo = '0;
    chk_reset_state("mid_mul_reset");
    @(posedge clk); #1;
    arst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_abort_ready", ready_out, 1);
    run_mult("mul_6x7", 32'd6, 32'd7, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
